decoder3_8_seq: RTL and testbench
=================================

# decoder3_8_seq

Sequenced 3-to-8 decoder. It turns a 3-bit binary code into a registered one-hot 8-bit output line and holds that line for a programmable number of cycles. It is the decode-side counterpart of the 8-to-3 encoder and drives one-hot select or enable lines downstream. It accepts single codes over a valid/ready handshake and also has an auto-scan mode that walks codes 0 through 7 in order.

## Interface

Parameters:
- PULSE_LEN, default 4: cycles each one-hot output is held; legal range 1..256.
- GAP_LEN, default 1: all-zero cycles after each pulse; legal range 0..256.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i  in  3  binary code to decode; sampled only on accept.
- i_valid  in  1  code request.
- i_ready  out  1  block can accept a code; combinational, equals !rst && state==IDLE && !scan.
- scan  in  1  start an auto-sweep of codes 0..7; sampled only in IDLE.
- y  out  8  registered one-hot output; 8'h00 when not pulsing.
- y_valid  out  1  registered; high while y is nonzero (PULSE state).
- busy  out  1  registered; high in PULSE or GAP.
- done  out  1  registered; one-cycle pulse at completion.

## Operation

- State machine: IDLE, PULSE, GAP.
- Internal state: 3-bit code register, scan-mode flag, and a 9-bit down-counter.
- IDLE:
  - scan=1: code<=0, scan flag<=1, go to PULSE with counter<=PULSE_LEN-1. scan has priority over i_valid, and i_ready is low that cycle.
  - i_valid && i_ready: code<=i, scan flag<=0, go to PULSE with counter<=PULSE_LEN-1.
- PULSE:
  - y = 1<<code, y_valid=1, counter decrements each cycle.
  - When counter==0 and GAP_LEN>0: go to GAP with counter<=GAP_LEN-1.
  - When counter==0 and GAP_LEN==0: take the end-of-step decision below directly.
- GAP: y=0, y_valid=0, counter decrements; at 0, take the end-of-step decision.
- End-of-step decision:
  - Scan flag set and code!=7: code<=code+1, go to PULSE, counter<=PULSE_LEN-1.
  - Otherwise: go to IDLE, done<=1.
- Code increment never wraps: a scan terminates after code 7.
- scan or i_valid changing while busy has no effect. A dropped scan does not abort a sweep, and i_valid is never accepted while busy.
- Exactly one bit of y is set whenever y_valid=1.

## Timing

- Reset values: y=8'h00, y_valid=0, busy=0, done=0, state IDLE, code 0, scan flag 0. i_ready is 0 during reset and 1 on the following cycle if scan is low.
- A reset asserted mid-operation takes effect at the next edge, forcing the reset values with no done pulse. Reset overrides every other input.
- Accept at edge N: y=1<<i, y_valid=1, busy=1 from cycle N+1 through N+PULSE_LEN.
- Gap cycles follow: N+PULSE_LEN+1 .. N+PULSE_LEN+GAP_LEN.
- First IDLE cycle is N+PULSE_LEN+GAP_LEN+1. done=1 and i_ready=1 in that cycle, so a new accept is possible then. done lasts exactly one cycle.
- Single-code latency is 1 cycle from accept to output; occupancy is PULSE_LEN+GAP_LEN cycles.
- A scan started at edge N occupies 8*(PULSE_LEN+GAP_LEN) cycles. done is in cycle N+8*(PULSE_LEN+GAP_LEN)+1.
- With GAP_LEN=0 consecutive scan pulses are back-to-back, and y changes directly from one one-hot value to the next with no zero cycle.

## Test plan

- Reset: rst=1 for 2 cycles mid-random stimulus -> y=8'h00, y_valid=0, busy=0, done=0; i_ready=1 on the first cycle after rst falls.
- Single decode, PULSE_LEN=4, GAP_LEN=1: i=3'd5, i_valid=1 accepted at edge N -> y=8'h20 in cycles N+1..N+4, y=8'h00 at N+5, done=1 and i_ready=1 at N+6. Repeat for all 8 codes and check the one-hot mapping.
- Scan, PULSE_LEN=4, GAP_LEN=1: scan pulse at edge N -> y runs 01,02,04,08,10,20,40,80, each held 4 cycles with one zero cycle between; done only at N+41.
- Back-to-back, PULSE_LEN=1, GAP_LEN=0: scan -> y=01..80 on 8 consecutive cycles, no zero between, done at N+9.
- Priority: scan=1 and i_valid=1 with i=3'd2 in the same IDLE cycle -> scan runs with first y=8'h01. No 8'h04 pulse appears, and i_valid held high during busy is never accepted.
- Reset mid-scan while y=8'h08 -> y=8'h00 and busy=0 on the next cycle, no done pulse, i_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/decoder3_8_seq.sv
// Sequenced 3-to-8 decoder: registered one-hot output held PULSE_LEN cycles,
// followed by GAP_LEN zero cycles; single codes via valid/ready or an auto-scan of 0..7.
module decoder3_8_seq #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i,
  input  logic       i_valid,
  output logic       i_ready,
  input  logic       scan,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [8:0] PL_M1 = 9'(PULSE_LEN - 1);
  localparam logic [8:0] GL_M1 = (GAP_LEN > 0) ? 9'(GAP_LEN - 1) : 9'd0;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       scan_q, scan_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] y_q, y_d;
  logic       yv_q, yv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       step_end;

  assign i_ready = !rst && (state_q == IDLE) && !scan;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    scan_d   = scan_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    step_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan) begin
          code_d  = 3'd0;
          scan_d  = 1'b1;
          state_d = PULSE;
          cnt_d   = PL_M1;
        end else if (i_valid && i_ready) begin
          code_d  = i;
          scan_d  = 1'b0;
          state_d = PULSE;
          cnt_d   = PL_M1;
        end
      end
      PULSE: begin
        if (cnt_q == 9'd0) begin
          if (GAP_LEN > 0) begin
            state_d = GAP;
            cnt_d   = GL_M1;
          end else begin
            step_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      GAP: begin
        if (cnt_q == 9'd0) step_end = 1'b1;
        else               cnt_d = cnt_q - 9'd1;
      end
      default: state_d = IDLE;
    endcase

    // A scan stops after code 7; the code register never wraps.
    if (step_end) begin
      if (scan_q && (code_q != 3'd7)) begin
        code_d  = code_q + 3'd1;
        state_d = PULSE;
        cnt_d   = PL_M1;
      end else begin
        state_d = IDLE;
        scan_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    // Outputs are registered from the next state so they line up with it.
    y_d    = (state_d == PULSE) ? (8'b1 << code_d) : 8'h00;
    yv_d   = (state_d == PULSE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
      scan_q  <= 1'b0;
      cnt_q   <= 9'd0;
      y_q     <= 8'h00;
      yv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      scan_q  <= scan_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y       = y_q;
  assign y_valid = yv_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_decoder3_8_seq.sv
// Directed bench: instance A (PULSE_LEN=4, GAP_LEN=1) and instance B (PULSE_LEN=1, GAP_LEN=0).
module tb_decoder3_8_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_i = '0;
  logic       a_iv = 1'b0, a_scan = 1'b0, a_rdy, a_yv, a_busy, a_done;
  logic [7:0] a_y;
  logic [2:0] b_i = '0;
  logic       b_iv = 1'b0, b_scan = 1'b0, b_rdy, b_yv, b_busy, b_done;
  logic [7:0] b_y;

  decoder3_8_seq #(.PULSE_LEN(4), .GAP_LEN(1)) u_a (
    .clk(clk), .rst(rst), .i(a_i), .i_valid(a_iv), .i_ready(a_rdy), .scan(a_scan),
    .y(a_y), .y_valid(a_yv), .busy(a_busy), .done(a_done));

  decoder3_8_seq #(.PULSE_LEN(1), .GAP_LEN(0)) u_b (
    .clk(clk), .rst(rst), .i(b_i), .i_valid(b_iv), .i_ready(b_rdy), .scan(b_scan),
    .y(b_y), .y_valid(b_yv), .busy(b_busy), .done(b_done));

  typedef struct {
    logic [2:0] code;
    logic [7:0] y;
  } vec_t;
  vec_t vecs[8];

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the first sample after the scan-start edge N (cycle N+1); returns at N+41.
  task automatic scan_body_a(input string nm);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk({nm, "_y"}, a_y, vecs[k].y);
        chk({nm, "_yv"}, a_yv, 1'b1);
        chk({nm, "_busy"}, a_busy, 1'b1);
        chk({nm, "_done_low"}, a_done, 1'b0);
        tick();
      end
      chk({nm, "_gap_y"}, a_y, 8'h00);
      chk({nm, "_gap_busy"}, a_busy, 1'b1);
      chk({nm, "_gap_done_low"}, a_done, 1'b0);
      tick();
    end
    chk({nm, "_done"}, a_done, 1'b1);
    chk({nm, "_end_y"}, a_y, 8'h00);
    chk({nm, "_end_busy"}, a_busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h01};
    vecs[1] = '{3'd1, 8'h02};
    vecs[2] = '{3'd2, 8'h04};
    vecs[3] = '{3'd3, 8'h08};
    vecs[4] = '{3'd4, 8'h10};
    vecs[5] = '{3'd5, 8'h20};
    vecs[6] = '{3'd6, 8'h40};
    vecs[7] = '{3'd7, 8'h80};

    // Reset, random traffic, then reset again for two cycles
    rst = 1'b1;
    tick(); tick();
    chk("rst0_y", a_y, 8'h00);
    chk("rst0_busy", a_busy, 1'b0);
    chk("rst0_rdy", a_rdy, 1'b0);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      a_i = 3'($urandom_range(0, 7));
      a_iv = 1'($urandom_range(0, 1));
      a_scan = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rst1_rdy", a_rdy, 1'b0);
    tick();
    a_iv = 1'b0; a_scan = 1'b0;
    chk("rst_y", a_y, 8'h00);
    chk("rst_yv", a_yv, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_b_y", b_y, 8'h00);
    rst = 1'b0;
    #1;
    chk("rst_rel_rdy", a_rdy, 1'b1);
    chk("rst_rel_b_rdy", b_rdy, 1'b1);

    // Single decodes over all codes
    foreach (vecs[v]) begin
      a_i = vecs[v].code;
      a_iv = 1'b1;
      #1;
      chk("sd_rdy", a_rdy, 1'b1);
      tick();
      a_iv = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        chk("sd_y", a_y, vecs[v].y);
        chk("sd_yv", a_yv, 1'b1);
        chk("sd_busy", a_busy, 1'b1);
        chk("sd_done_low", a_done, 1'b0);
        tick();
      end
      chk("sd_gap_y", a_y, 8'h00);
      chk("sd_gap_yv", a_yv, 1'b0);
      chk("sd_gap_busy", a_busy, 1'b1);
      tick();
      chk("sd_done", a_done, 1'b1);
      chk("sd_end_rdy", a_rdy, 1'b1);
      chk("sd_end_busy", a_busy, 1'b0);
      tick();
      chk("sd_done_1cyc", a_done, 1'b0);
    end

    // Full scan with gaps
    a_scan = 1'b1;
    tick();
    a_scan = 1'b0;
    scan_body_a("scan");
    tick();
    chk("scan_done_1cyc", a_done, 1'b0);

    // scan beats i_valid; i_valid held high is ignored while busy
    a_scan = 1'b1; a_iv = 1'b1; a_i = 3'd2;
    #1;
    chk("prio_rdy_low", a_rdy, 1'b0);
    tick();
    a_scan = 1'b0;
    chk("prio_first_y", a_y, 8'h01);
    scan_body_a("prio");
    a_iv = 1'b0;
    tick();
    chk("prio_idle_busy", a_busy, 1'b0);

    // Reset in the middle of a scan, while y=08
    a_scan = 1'b1;
    tick();
    a_scan = 1'b0;
    for (int n = 0; n < 15; n++) tick();
    chk("mrst_pre_y", a_y, 8'h08);
    rst = 1'b1;
    tick();
    chk("mrst_y", a_y, 8'h00);
    chk("mrst_busy", a_busy, 1'b0);
    chk("mrst_yv", a_yv, 1'b0);
    chk("mrst_done", a_done, 1'b0);
    chk("mrst_rdy", a_rdy, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst_rel_rdy", a_rdy, 1'b1);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("mrst_no_done", a_done, 1'b0);
      chk("mrst_idle_busy", a_busy, 1'b0);
    end

    // Back-to-back scan, PULSE_LEN=1 and GAP_LEN=0
    b_scan = 1'b1;
    tick();
    b_scan = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_y", b_y, vecs[k].y);
      chk("b2b_yv", b_yv, 1'b1);
      chk("b2b_done_low", b_done, 1'b0);
      tick();
    end
    chk("b2b_done", b_done, 1'b1);
    chk("b2b_end_y", b_y, 8'h00);
    chk("b2b_end_rdy", b_rdy, 1'b1);
    tick();
    chk("b2b_done_1cyc", b_done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
